// File: rtl/seven_segment_scan_ctrl_if.sv
// Display-data and scan-output bundle for seven_segment_scan_ctrl; zero latency, no backpressure.
// The master side supplies nibbles/dp/enables plus the load strobe and observes the registered scan outputs.
interface seven_segment_scan_ctrl_if #(
    parameter int NUM_DIGITS = 4
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic [NUM_DIGITS-1:0]   digit_en;
    logic                    load;
    logic [3:0]              digit_data;
    logic                    dp_n;
    logic [NUM_DIGITS-1:0]   anode;
    logic [IDX_W-1:0]        digit_idx;
    logic                    frame_done;

    modport master (
        output data_in, dp_in, digit_en, load,
        input  digit_data, dp_n, anode, digit_idx, frame_done
    );

    modport slave (
        input  data_in, dp_in, digit_en, load,
        output digit_data, dp_n, anode, digit_idx, frame_done
    );
endinterface

// File: rtl/seven_segment_scan_ctrl.sv
// Seven-segment scan controller: BLANK/ON slot per digit, double-buffered display data swapped at frame boundaries.
// Outputs are registered (one-cycle latency from state change); load is always accepted, never backpressured.
module seven_segment_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int ON_CYCLES    = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    seven_segment_scan_ctrl_if.slave bus
);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int MAX_CYC = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_ON    = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [NUM_DIGITS-1:0]      anode_q, anode_d;
    logic [3:0]                 digit_data_q, digit_data_d;
    logic                       dp_n_q, dp_n_d;
    logic                       frame_done_q, frame_done_d;

    logic [NUM_DIGITS-1:0][3:0] shd_data_q, shd_data_d;
    logic [NUM_DIGITS-1:0]      shd_dp_q, shd_dp_d;
    logic [NUM_DIGITS-1:0]      shd_en_q, shd_en_d;
    logic [NUM_DIGITS-1:0][3:0] pnd_data_q, pnd_data_d;
    logic [NUM_DIGITS-1:0]      pnd_dp_q, pnd_dp_d;
    logic [NUM_DIGITS-1:0]      pnd_en_q, pnd_en_d;
    logic                       pnd_vld_q, pnd_vld_d;

    logic                       enter_blank;
    logic                       boundary;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        anode_d      = anode_q;
        digit_data_d = digit_data_q;
        dp_n_d       = dp_n_q;
        frame_done_d = 1'b0;
        shd_data_d   = shd_data_q;
        shd_dp_d     = shd_dp_q;
        shd_en_d     = shd_en_q;
        pnd_data_d   = pnd_data_q;
        pnd_dp_d     = pnd_dp_q;
        pnd_en_d     = pnd_en_q;
        pnd_vld_d    = pnd_vld_q;
        enter_blank  = 1'b0;
        boundary     = 1'b0;

        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_ON;
                    cnt_d   = '0;
                    if (shd_en_q[idx_q]) begin
                        anode_d = ~(NUM_DIGITS'(1) << idx_q);
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ON: begin
                if (cnt_q == ON_LAST) begin
                    state_d     = ST_BLANK;
                    cnt_d       = '0;
                    anode_d     = '1;
                    enter_blank = 1'b1;
                    boundary    = (idx_q == IDX_LAST);
                    idx_d       = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_BLANK;
                cnt_d   = '0;
                anode_d = '1;
            end
        endcase

        // A load landing on the boundary edge bypasses pending and goes straight to shadow.
        if (boundary) begin
            frame_done_d = 1'b1;
            pnd_vld_d    = 1'b0;
            if (bus.load) begin
                shd_data_d = bus.data_in;
                shd_dp_d   = bus.dp_in;
                shd_en_d   = bus.digit_en;
            end else if (pnd_vld_q) begin
                shd_data_d = pnd_data_q;
                shd_dp_d   = pnd_dp_q;
                shd_en_d   = pnd_en_q;
            end
        end else if (bus.load) begin
            pnd_data_d = bus.data_in;
            pnd_dp_d   = bus.dp_in;
            pnd_en_d   = bus.digit_en;
            pnd_vld_d  = 1'b1;
        end

        // Decoder inputs change only at slot start so segments settle during the blanking guard.
        if (enter_blank) begin
            digit_data_d = shd_data_d[idx_d];
            dp_n_d       = ~shd_dp_d[idx_d];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            cnt_q        <= '0;
            idx_q        <= '0;
            anode_q      <= '1;
            digit_data_q <= '0;
            dp_n_q       <= 1'b1;
            frame_done_q <= 1'b0;
            shd_data_q   <= '0;
            shd_dp_q     <= '0;
            shd_en_q     <= '0;
            pnd_data_q   <= '0;
            pnd_dp_q     <= '0;
            pnd_en_q     <= '0;
            pnd_vld_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            anode_q      <= anode_d;
            digit_data_q <= digit_data_d;
            dp_n_q       <= dp_n_d;
            frame_done_q <= frame_done_d;
            shd_data_q   <= shd_data_d;
            shd_dp_q     <= shd_dp_d;
            shd_en_q     <= shd_en_d;
            pnd_data_q   <= pnd_data_d;
            pnd_dp_q     <= pnd_dp_d;
            pnd_en_q     <= pnd_en_d;
            pnd_vld_q    <= pnd_vld_d;
        end
    end

    assign bus.anode      = anode_q;
    assign bus.digit_data = digit_data_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.digit_idx  = idx_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_seven_segment_scan_ctrl.sv
// Bench for seven_segment_scan_ctrl with 4 digits, ON=8, BLANK=2 (10-cycle slots, 40-cycle frames).
// Each frame is checked cycle by cycle against hand-written per-digit expectations.
module tb_seven_segment_scan_ctrl;
    localparam int ND = 4;
    localparam int SLOT = 10;
    localparam int FRAME = ND * SLOT;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  en;
        logic [15:0] exp_data;
        logic [3:0]  exp_dpn;
        logic [15:0] exp_an;
    } vec_t;

    typedef struct {
        int          at;
        logic [15:0] data;
        logic [3:0]  dp;
        logic [3:0]  en;
    } ld_t;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;
    bit   mon_en;

    seven_segment_scan_ctrl_if #(.NUM_DIGITS(ND)) bus ();

    seven_segment_scan_ctrl #(
        .NUM_DIGITS  (ND),
        .ON_CYCLES   (8),
        .BLANK_CYCLES(2)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (mon_en) check("anode_onehot", 32'($countones(~bus.anode) <= 1), 32'd1);
    end

    // Checks one full frame; optional loads are driven right after sampling the given cycle.
    task automatic check_frame(input bit first, input string name,
                               input logic [15:0] ed, input logic [3:0] edpn, input logic [15:0] ean,
                               input ld_t l1, input ld_t l2);
        for (int c = (first ? 1 : 0); c < FRAME; c++) begin
            int k;
            int j;
            logic [11:0] exp;
            k = c / SLOT;
            j = c % SLOT;
            step();
            exp = {((j < 2) ? 4'hF : ean[4*k +: 4]), ed[4*k +: 4], edpn[k], 2'(k), (c == 0 && !first)};
            check($sformatf("%s_c%0d", name, c),
                  {20'd0, bus.anode, bus.digit_data, bus.dp_n, bus.digit_idx, bus.frame_done},
                  {20'd0, exp});
            if (l1.at == c) begin
                bus.load = 1'b1; bus.data_in = l1.data; bus.dp_in = l1.dp; bus.digit_en = l1.en;
            end else if (l2.at == c) begin
                bus.load = 1'b1; bus.data_in = l2.data; bus.dp_in = l2.dp; bus.digit_en = l2.en;
            end else begin
                bus.load = 1'b0;
            end
        end
    endtask

    vec_t vecs[3];
    ld_t  none_ld;
    ld_t  l_a;
    ld_t  l_b;

    initial begin
        n_pass  = 0;
        n_total = 0;
        mon_en  = 1'b1;
        vecs[0] = '{data: 16'h1234, dp: 4'b0010, en: 4'b1111,
                    exp_data: 16'h1234, exp_dpn: 4'b1101, exp_an: 16'h7BDE};
        vecs[1] = '{data: 16'h1234, dp: 4'b0000, en: 4'b0101,
                    exp_data: 16'h1234, exp_dpn: 4'b1111, exp_an: 16'hFBFE};
        vecs[2] = '{data: 16'h9F0E, dp: 4'b1001, en: 4'b1010,
                    exp_data: 16'h9F0E, exp_dpn: 4'b0110, exp_an: 16'h7FDF};
        none_ld = '{at: -1, data: 16'h0, dp: 4'h0, en: 4'h0};

        rst_n        = 1'b0;
        bus.load     = 1'b0;
        bus.data_in  = '0;
        bus.dp_in    = '0;
        bus.digit_en = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_anode", {28'd0, bus.anode}, 32'hF);
        check("rst_dp_n", {31'd0, bus.dp_n}, 32'd1);
        check("rst_digit_data", {28'd0, bus.digit_data}, 32'd0);
        check("rst_frame_done", {31'd0, bus.frame_done}, 32'd0);
        check("rst_digit_idx", {30'd0, bus.digit_idx}, 32'd0);
        rst_n = 1'b1;

        l_a = '{at: 5, data: vecs[0].data, dp: vecs[0].dp, en: vecs[0].en};
        check_frame(1'b1, "frame0", 16'h0000, 4'hF, 16'hFFFF, l_a, none_ld);

        for (int i = 0; i < 3; i++) begin
            if (i < 2) l_a = '{at: 5, data: vecs[i+1].data, dp: vecs[i+1].dp, en: vecs[i+1].en};
            else       l_a = '{at: 12, data: 16'hABCD, dp: 4'h0, en: 4'hF};
            check_frame(1'b0, $sformatf("vec%0d", i), vecs[i].exp_data, vecs[i].exp_dpn, vecs[i].exp_an,
                        l_a, none_ld);
        end

        // Two loads in one frame: the later one must be the one displayed next.
        l_a = '{at: 12, data: 16'h9999, dp: 4'h0, en: 4'hF};
        l_b = '{at: 25, data: 16'h5555, dp: 4'h0, en: 4'hF};
        check_frame(1'b0, "abcd", 16'hABCD, 4'hF, 16'h7BDE, l_a, l_b);

        l_a = '{at: FRAME - 1, data: 16'h00F0, dp: 4'h0, en: 4'hF};
        check_frame(1'b0, "last_wins", 16'h5555, 4'hF, 16'h7BDE, l_a, none_ld);
        check_frame(1'b0, "bnd_load", 16'h00F0, 4'hF, 16'h7BDE, none_ld, none_ld);

        repeat (25) step();
        check("pre_rst_anode", {28'd0, bus.anode}, 32'hB);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_anode", {28'd0, bus.anode}, 32'hF);
        check("async_rst_idx", {30'd0, bus.digit_idx}, 32'd0);
        check("async_rst_data", {28'd0, bus.digit_data}, 32'd0);
        #1 rst_n = 1'b1;
        check_frame(1'b1, "post_rst0", 16'h0000, 4'hF, 16'hFFFF, none_ld, none_ld);
        check_frame(1'b0, "post_rst1", 16'h0000, 4'hF, 16'hFFFF, none_ld, none_ld);

        mon_en = 1'b0;
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
